// File: rtl/analog_io_monitor.sv
// Wishbone pad manager for the six analog-capable GPIOs io[17:12], plus a
// gated edge counter on one selected pad's digital receiver.
module analog_io_monitor #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [5:0]  io_in,
    output logic [5:0]  io_out,
    output logic [5:0]  io_oeb,
    output logic        irq
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    localparam logic [31:0] CTRL_WMASK = 32'h0002_FFFF;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] gate_q, gate_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic        done_q, done_d;
    logic        badch_q, badch_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic [2:0]  ch_q, ch_d;
    logic        both_q, both_d;
    logic [5:0]  sync1_q, sync1_d;
    logic [5:0]  sync2_q, sync2_d;
    logic [5:0]  hist_q, hist_d;
    logic [5:0]  oeb_q, oeb_d;
    logic [5:0]  out_q, out_d;
    logic        irq_q, irq_d;

    logic [31:0] sel_mask;
    logic [5:0]  pad_out_next;
    logic        hit, req, wr, rd;
    logic [1:0]  idx;
    logic [31:0] rdata;
    logic [7:0]  rise_v, any_v;
    logic        edge_hit;
    logic [31:0] cnt_inc, cnt_next;
    logic        w1c, set_done;
    logic        unused_adr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign sel_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end
        // Analog pads (DRV=0) always present out=1 alongside oeb=1.
        for (gi = 0; gi < 6; gi++) begin : g_pad
            assign pad_out_next[gi] = ctrl_q[gi] ? ctrl_q[6+gi] : 1'b1;
        end
    endgenerate

    assign unused_adr = ^wbs_adr_i[1:0];

    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req = hit & ~ack_q;
    assign wr  = req & wbs_we_i;
    assign rd  = req & ~wbs_we_i;
    assign idx = wbs_adr_i[3:2];

    always_comb begin
        rdata = 32'd0;
        case (idx)
            2'd0: rdata = ctrl_q;
            2'd1: rdata = gate_q;
            2'd2: rdata = count_q;
            default: rdata = {18'd0, sync2_q, 5'd0, badch_q, done_q, state_q == S_COUNT};
        endcase
    end

    assign rise_v   = {2'b00, sync2_q & ~hist_q};
    assign any_v    = {2'b00, sync2_q ^ hist_q};
    assign edge_hit = both_q ? any_v[ch_q] : rise_v[ch_q];
    assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign cnt_next = edge_hit ? cnt_inc : cnt_q;

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        gate_d   = gate_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        done_d   = done_q;
        badch_d  = badch_q;
        ch_d     = ch_q;
        both_d   = both_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        w1c      = 1'b0;
        set_done = 1'b0;
        ack_d    = req;
        dat_d    = rd ? rdata : 32'd0;
        sync1_d  = io_in;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;

        if (wr) begin
            case (idx)
                2'd0: begin
                    ctrl_d  = (ctrl_q & ~(sel_mask & CTRL_WMASK)) | (wbs_dat_i & sel_mask & CTRL_WMASK);
                    start_d = wbs_sel_i[2] & wbs_dat_i[16];
                    abort_d = wbs_sel_i[2] & wbs_dat_i[18];
                end
                2'd1: gate_d = (gate_q & ~sel_mask) | (wbs_dat_i & sel_mask);
                2'd3: w1c = wbs_sel_i[0] & wbs_dat_i[1];
                default: ;
            endcase
        end

        // START/ABORT pulses are registered, so they act on the CTRL value just written.
        if (state_q == S_COUNT && abort_q) begin
            state_d = S_IDLE;
        end else if (start_q) begin
            if (ctrl_q[14:12] >= 3'd6) begin
                badch_d = 1'b1;
                state_d = S_IDLE;
            end else if (gate_q == 32'd0) begin
                badch_d  = 1'b0;
                count_d  = 32'd0;
                set_done = 1'b1;
                state_d  = S_IDLE;
            end else begin
                badch_d = 1'b0;
                state_d = S_COUNT;
                rem_d   = gate_q;
                cnt_d   = 32'd0;
                ch_d    = ctrl_q[14:12];
                both_d  = ctrl_q[15];
            end
        end else if (state_q == S_COUNT) begin
            if (rem_q == 32'd1) begin
                count_d  = cnt_next;
                set_done = 1'b1;
                state_d  = S_IDLE;
            end else begin
                rem_d = rem_q - 32'd1;
                cnt_d = cnt_next;
            end
        end

        if (w1c) done_d = 1'b0;
        if (set_done) done_d = 1'b1;

        oeb_d = ~ctrl_q[5:0];
        out_d = pad_out_next;
        irq_d = done_d & ctrl_d[17];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            ctrl_q  <= 32'd0;
            gate_q  <= 32'd0;
            count_q <= 32'd0;
            cnt_q   <= 32'd0;
            rem_q   <= 32'd0;
            done_q  <= 1'b0;
            badch_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            ch_q    <= 3'd0;
            both_q  <= 1'b0;
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
            hist_q  <= 6'd0;
            oeb_q   <= 6'h3F;
            out_q   <= 6'h3F;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            ctrl_q  <= ctrl_d;
            gate_q  <= gate_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            badch_q <= badch_d;
            start_q <= start_d;
            abort_q <= abort_d;
            ch_q    <= ch_d;
            both_q  <= both_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            oeb_q   <= oeb_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_oeb    = oeb_q;
    assign io_out    = out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_analog_io_monitor.sv
// Directed bench for analog_io_monitor: bus expectations go through a scoreboard
// queue drained by an ack monitor; pad and irq timing is checked inline.
module tb_analog_io_monitor;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [5:0]  io_in;
    logic [5:0]  io_out, io_oeb;
    logic        irq;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_total  = 0;
    int   n_passed = 0;
    logic prev_ack = 1'b0;

    analog_io_monitor #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    // Ack monitor: every ack pops one expectation; read data must be 0 outside ack.
    always @(negedge clk) begin
        if (ack) begin
            check("ack_one_cycle", 32'(prev_ack), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, rdat & e.mask, e.exp & e.mask);
                $display("bus %s: dat 0x%08h (mask 0x%08h)", e.name, rdat, e.mask);
            end
        end else begin
            check("dat_idle", rdat, 32'd0);
        end
        prev_ack <= ack;
    end

    // Square wave on io_in[2], period 10 cycles.
    initial begin
        int ph;
        ph = 0;
        io_in = 6'd0;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            if (ph == 5) begin
                ph = 0;
                io_in[2] = ~io_in[2];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access: request in cycle c, ack required in c+1, bus idle in c+2.
    task automatic bus(input logic w, input logic [1:0] ridx, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input logic [31:0] mask,
                       input string name);
        exp_t e;
        e.exp  = w ? 32'd0 : exp;
        e.mask = w ? 32'hFFFF_FFFF : mask;
        e.name = name;
        sb_q.push_back(e);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = BASE | {28'd0, ridx, 2'b00};
        wdat = d;
        sel  = s;
        tick(1);
        check({name, "_ack"}, 32'(ack), 32'd1);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        tick(1);
        check({name, "_ack_low"}, 32'(ack), 32'd0);
    endtask

    task automatic wr(input logic [1:0] ridx, input logic [31:0] d, input string name);
        bus(1'b1, ridx, d, 4'hF, 32'd0, 32'd0, name);
    endtask

    task automatic rd(input logic [1:0] ridx, input logic [31:0] exp, input logic [31:0] mask,
                      input string name);
        bus(1'b0, ridx, 32'd0, 4'hF, exp, mask, name);
    endtask

    // Starts a window (task returns at START ack + 1) and checks irq edges at +GATE / +GATE+1.
    task automatic run_window(input logic [31:0] ctrl, input int gate, input string name);
        wr(2'd0, ctrl, {name, "_start"});
        tick(gate - 1);
        check({name, "_irq_before"}, 32'(irq), 32'd0);
        tick(1);
        check({name, "_irq_after"}, 32'(irq), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        sel  = 4'h0;
        adr  = 32'd0;
        wdat = 32'd0;
        tick(3);
        check("rst_oeb", 32'(io_oeb), 32'h3F);
        check("rst_out", 32'(io_out), 32'h3F);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        rst = 1'b0;
        tick(1);

        rd(2'd0, 32'd0, 32'hFFFF_FFFF, "rst_ctrl");
        rd(2'd1, 32'd0, 32'hFFFF_FFFF, "rst_gate");
        rd(2'd2, 32'd0, 32'hFFFF_FFFF, "rst_count");
        rd(2'd3, 32'd0, 32'h7, "rst_status");

        // DRV=000101, OUT=000001
        wr(2'd0, 32'h45, "ctrl_pads");
        check("pad_oeb", 32'(io_oeb), 32'h3A);
        check("pad_out", 32'(io_out), 32'h3B);
        bus(1'b1, 2'd0, 32'h0000_FF00, 4'b0010, 32'd0, 32'd0, "ctrl_lane1");
        rd(2'd0, 32'h0000_FF45, 32'hFFFF_FFFF, "ctrl_lane1_rb");
        check("lane_oeb", 32'(io_oeb), 32'h3A);
        check("lane_out", 32'(io_out), 32'h3F);
        wr(2'd0, 32'h0, "ctrl_analog");
        check("analog_oeb", 32'(io_oeb), 32'h3F);

        // Rising edges, CH=2, GATE=100
        wr(2'd1, 32'd100, "gate100");
        rd(2'd1, 32'd100, 32'hFFFF_FFFF, "gate100_rb");
        run_window(32'h0003_2000, 100, "rise");
        rd(2'd2, 32'd10, 32'hFFFF_FFFF, "rise_count");
        rd(2'd3, 32'h2, 32'h7, "rise_status");
        tick(20);
        check("irq_held", 32'(irq), 32'd1);
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_done");
        check("irq_cleared", 32'(irq), 32'd0);
        rd(2'd3, 32'h0, 32'h7, "status_cleared");

        // Both edges
        run_window(32'h0003_A000, 100, "both");
        rd(2'd2, 32'd20, 32'hFFFF_FFFF, "both_count");
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_done2");

        // Invalid channel
        wr(2'd0, 32'h0003_6000, "start_ch6");
        rd(2'd3, 32'h4, 32'h7, "badch_status");
        rd(2'd2, 32'd20, 32'hFFFF_FFFF, "badch_count");
        check("badch_irq", 32'(irq), 32'd0);

        // Abort, then restart mid-window
        wr(2'd1, 32'd1000, "gate1000");
        wr(2'd0, 32'h0003_2000, "long_start");
        tick(200);
        wr(2'd0, 32'h0006_2000, "abort");
        rd(2'd3, 32'h0, 32'h7, "abort_status");
        rd(2'd2, 32'd20, 32'hFFFF_FFFF, "abort_count");
        check("abort_irq", 32'(irq), 32'd0);
        wr(2'd0, 32'h0003_2000, "long_start2");
        tick(300);
        run_window(32'h0003_2000, 1000, "restart");
        rd(2'd2, 32'd100, 32'hFFFF_FFFF, "restart_count");
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_done3");

        // GATE=0: immediate result
        wr(2'd1, 32'd0, "gate0");
        wr(2'd0, 32'h0003_2000, "gate0_start");
        check("gate0_irq", 32'(irq), 32'd1);
        rd(2'd2, 32'd0, 32'hFFFF_FFFF, "gate0_count");
        rd(2'd3, 32'h2, 32'h7, "gate0_status");
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_done4");

        // W1C landing on the completion edge: set wins
        wr(2'd1, 32'd5, "gate5");
        wr(2'd0, 32'h0003_2000, "gate5_start");
        tick(4);
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_race");
        check("race_irq", 32'(irq), 32'd1);
        rd(2'd3, 32'h2, 32'h7, "race_status");
        bus(1'b1, 2'd3, 32'h2, 4'b0001, 32'd0, 32'd0, "w1c_done5");
        check("race_irq_clr", 32'(irq), 32'd0);

        // Reset mid-window with all pads driven low
        wr(2'd1, 32'd1000, "gate_rst");
        wr(2'd0, 32'h0003_203F, "rst_start");
        check("drive_oeb", 32'(io_oeb), 32'h00);
        check("drive_out", 32'(io_out), 32'h00);
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_oeb", 32'(io_oeb), 32'h3F);
        check("midrst_out", 32'(io_out), 32'h3F);
        rd(2'd3, 32'h0, 32'h7, "midrst_status");
        rd(2'd0, 32'd0, 32'hFFFF_FFFF, "midrst_ctrl");
        rd(2'd1, 32'd0, 32'hFFFF_FFFF, "midrst_gate");
        rd(2'd2, 32'd0, 32'hFFFF_FFFF, "midrst_count");
        tick(1000);
        check("midrst_no_irq", 32'(irq), 32'd0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
